// File: rtl/fifo.sv
// Single-clock FIFO with show-ahead reads and registered full/empty flags.
// The head word is presented combinationally on data_out whenever the FIFO is not empty.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             wr_en;
    logic             rd_en;

    // Handshake: a write is accepted when w_valid=1 and fifo_full=0; a read is
    // accepted when r_ready=1 and fifo_empty=0. Both may be accepted in one cycle.
    // Requests that are not accepted have no effect and need not be held.
    assign fifo_full  = (cnt == CNT_W'(DEPTH));
    assign fifo_empty = (cnt == '0);
    assign wr_en      = w_valid & ~fifo_full;
    assign rd_en      = r_ready & ~fifo_empty;
    assign data_out   = fifo_empty ? '0 : mem[rp];

    // Storage is not reset; only pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) begin
                wp <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
            end
            if (rd_en) begin
                rp <= (rp == PTR_W'(DEPTH - 1)) ? '0 : rp + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                cnt <= cnt + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed and random checks of the fifo block at WIDTH=64, DEPTH=2.
// Each scenario task drives its stimulus and compares outputs inline.
module tb_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             w_valid;
    logic [WIDTH-1:0] data_in;
    logic             r_ready;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] exp_q[$];

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_valid    (w_valid),
        .data_in    (data_in),
        .r_ready    (r_ready),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then stable 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_valid = 1'b0;
        r_ready = 1'b0;
        data_in = '0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        w_valid = 1'b1;
        data_in = 64'hDEAD;
        r_ready = 1'b1;
        step();
        rst_n = 1'b1;
        idle();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_out); end
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL empty_read_empty got=%b exp=1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL empty_read_full got=%b exp=0", fifo_full); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL empty_read_data got=%h exp=0", data_out); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL fill_pre_full[%0d] got=%b exp=0", i, fifo_full); end
            w_valid = 1'b1;
            data_in = WIDTH'(i);
            step();
            n_cmp++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, fifo_empty); end
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", fifo_full); end
        data_in = 64'd2;
        step();
        idle();
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL overflow_full got=%b exp=1", fifo_full); end
        n_cmp++; if (data_out !== 64'd0) begin n_err++; $display("FAIL overflow_head got=%h exp=0", data_out); end
    endtask

    task automatic test_drain();
        r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (data_out !== WIDTH'(i)) begin n_err++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, WIDTH'(i)); end
            step();
            n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL drain_full[%0d] got=%b exp=0", i, fifo_full); end
        end
        idle();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL drain_data_zero got=%h exp=0", data_out); end
    endtask

    task automatic test_simultaneous();
        w_valid = 1'b1;
        data_in = 64'hA;
        step();
        data_in = 64'hB;
        r_ready = 1'b1;
        n_cmp++; if (data_out !== 64'hA) begin n_err++; $display("FAIL simul_read got=%h exp=a", data_out); end
        step();
        idle();
        n_cmp++; if (data_out !== 64'hB) begin n_err++; $display("FAIL simul_next_head got=%h exp=b", data_out); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL simul_full got=%b exp=0", fifo_full); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b exp=0", fifo_empty); end
        r_ready = 1'b1;
        step();
        idle();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL simul_drained got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_reset_mid();
        w_valid = 1'b1;
        data_in = 64'h55;
        step();
        rst_n   = 1'b0;
        data_in = 64'h66;
        step();
        rst_n = 1'b1;
        idle();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL midreset_empty got=%b exp=1", fifo_empty); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL midreset_data got=%h exp=0", data_out); end
    endtask

    task automatic test_streaming();
        int next_wr;
        int next_rd;
        int cycles;
        next_wr = 0;
        next_rd = 0;
        cycles  = 0;
        while (next_rd < 100 && cycles < 400) begin
            w_valid = ~fifo_full && (next_wr < 100);
            data_in = WIDTH'(next_wr);
            r_ready = ~fifo_empty;
            if (r_ready) begin
                n_cmp++;
                if (data_out !== WIDTH'(next_rd)) begin
                    n_err++;
                    $display("FAIL stream_data[%0d] got=%h exp=%h", next_rd, data_out, WIDTH'(next_rd));
                end
                next_rd++;
            end
            if (w_valid) next_wr++;
            step();
            cycles++;
        end
        idle();
        n_cmp++; if (cycles !== 101) begin n_err++; $display("FAIL stream_cycles got=%0d exp=101", cycles); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL stream_end_empty got=%b exp=1", fifo_empty); end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        logic wr_acc;
        logic rd_acc;
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w_valid = w;
            r_ready = r;
            data_in = {$urandom, $urandom};
            n_cmp++; if (fifo_full !== (exp_q.size() == DEPTH)) begin n_err++; $display("FAIL rand_full[%0d] got=%b exp=%b", i, fifo_full, exp_q.size() == DEPTH); end
            n_cmp++; if (fifo_empty !== (exp_q.size() == 0)) begin n_err++; $display("FAIL rand_empty[%0d] got=%b exp=%b", i, fifo_empty, exp_q.size() == 0); end
            wr_acc = w && (exp_q.size() < DEPTH);
            rd_acc = r && (exp_q.size() > 0);
            if (rd_acc) begin
                n_cmp++;
                if (data_out !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data[%0d] got=%h exp=%h", i, data_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (wr_acc) exp_q.push_back(data_in);
            step();
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst_n = 1'b1;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_reset_mid();
        test_streaming();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in first-out buffer with a parameterised width and depth. It decouples a producer (`w_valid`/`data_in`) from a consumer (`r_ready`/`data_out`) within one clock domain. The block uses show-ahead (first-word-fall-through) reads and registered full/empty status flags. It is a generic buffering primitive for datapath stages that need elastic storage.

## Interface

Parameters:
- `WIDTH`, default 32: data word width in bits (≥1).
- `DEPTH`, default 8: number of storage entries (≥2; need not be a power of two).

Ports:
- `clk`, input, 1: the single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset; synchronous and active-low.
- `w_valid`, input, 1: write request; `data_in` is written this cycle if accepted.
- `data_in`, input, `WIDTH`: write data.
- `r_ready`, input, 1: read request; the head word is consumed this cycle if accepted.
- `data_out`, output, `WIDTH`: current head word (oldest entry), valid whenever `fifo_empty`=0.
- `fifo_full`, output, 1: high when occupancy == `DEPTH`.
- `fifo_empty`, output, 1: high when occupancy == 0.

## Operation

- Storage: `DEPTH`×`WIDTH` register array, write pointer `wp`, read pointer `rp` (each `$clog2(DEPTH)` bits), occupancy counter `cnt` (`$clog2(DEPTH+1)` bits).
- Write accept: `wr_en = w_valid & ~fifo_full`. On `wr_en`, `mem[wp] <= data_in`, and `wp` advances. `wp` wraps from `DEPTH-1` to 0.
- Read accept: `rd_en = r_ready & ~fifo_empty`. On `rd_en`, `rp` advances with the same wrap rule.
- Counter updates:
  - `wr_en` only: `cnt+1`.
  - `rd_en` only: `cnt-1`.
  - Both: `cnt` unchanged.
  - Neither: unchanged.
- Flags are decoded from registered `cnt` only: `fifo_full = (cnt==DEPTH)`, `fifo_empty = (cnt==0)`. They never depend combinationally on `w_valid`/`r_ready`, so upstream logic may gate its requests on the flags without creating a loop.
- `data_out = fifo_empty ? '0 : mem[rp]`. This is a combinational read of the head, so it is the word being consumed in the cycle `rd_en` is high.
- Write while full: ignored. Memory, pointers and `cnt` are unchanged, even if `r_ready` is also high that cycle.
- Read while empty: ignored. There is no write-to-read bypass, so a word written into an empty FIFO is not readable in the same cycle.
- Simultaneous accepted write and read (0<cnt<DEPTH): both are performed. When cnt==1 the head is consumed and the new word becomes the next head.
- Ordering: words leave in exactly the order accepted, with no loss or duplication across pointer wrap.

## Timing

- Reset (`rst_n`=0 at a rising edge):
  - `wp`, `rp` and `cnt` are set to 0.
  - After that edge, `fifo_empty`=1, `fifo_full`=0 and `data_out`=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words at that edge; `w_valid`/`r_ready` are ignored in that cycle.
- Write latency: a word accepted at edge N is visible on `data_out` after edge N when it is the head. `fifo_empty` falls after edge N.
- Read: `data_out` shows the head before the consuming edge. After the edge it shows the next entry, or 0 if the FIFO is now empty.
- Flag update: `fifo_full` rises after the edge that accepts the `DEPTH`-th word and falls after the next accepted read.
- Throughput: one write and one read per cycle, sustained.

## Test plan

- Reset/empty: assert `rst_n`=0 for one edge, then release -> `fifo_empty`=1, `fifo_full`=0, `data_out`=0; a read with `r_ready`=1 changes nothing.
- Fill to full (`DEPTH`=2, `WIDTH`=64): write 0 and then 1 with no reads -> `fifo_full`=0 before each write and 1 after the second. A third write of value 2 while full is dropped; `fifo_full` stays 1 and the contents stay {0,1}.
- Drain: from the full state, read continuously -> `data_out`=0 then 1 at the consuming edges; `fifo_empty`=1 after the second read.
- Streaming: with `w_valid`=`~fifo_full` and `r_ready`=`~fifo_empty`, push 0..99 -> the pop sequence is exactly 0..99, pointers wrap many times, and there is no stall beyond the first cycle.
- Simultaneous ops: with one word (0xA) stored, write 0xB and read in the same cycle -> the read returns 0xA, `cnt` stays 1, the next head is 0xB, and both flags stay low.
- Random: 600 iterations of random push/pop enables and random data, checked against a reference queue -> every popped word matches, `fifo_full` matches occupancy==`DEPTH`, and `fifo_empty` matches occupancy==0.
